// File: rtl/cam_pixel_capture_if.sv
// Camera byte-stream inputs and frame-buffer write outputs of the pixel capture block.
// The slave side is the capture block; the master side is the camera/buffer environment.
interface cam_pixel_capture_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              capture_en_in;
   logic              vsync_in;
   logic              href_in;
   logic [7:0]        data_in;
   logic [15:0]       pixel_out;
   logic [ADDR_W-1:0] addr_out;
   logic              we_out;
   logic              frame_done_out;
   logic              clip_out;
   logic              odd_byte_out;
   logic [7:0]        frame_count_out;

   modport master (
      output capture_en_in, vsync_in, href_in, data_in,
      input  pixel_out, addr_out, we_out, frame_done_out, clip_out, odd_byte_out,
             frame_count_out
   );

   modport slave (
      input  capture_en_in, vsync_in, href_in, data_in,
      output pixel_out, addr_out, we_out, frame_done_out, clip_out, odd_byte_out,
             frame_count_out
   );
endinterface

// File: rtl/cam_pixel_capture.sv
// Assembles RGB565 pixels from the camera byte stream and writes them to the frame buffer
// at row*WIDTH+col, clipping oversize frames and flagging odd-length lines.
module cam_pixel_capture #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned ADDR_W = 17
) (
   input logic                clk_in,
   input logic                rst_n_in,
   cam_pixel_capture_if.slave cam
);
   localparam int unsigned ColW = $clog2(WIDTH + 1);
   localparam int unsigned RowW = $clog2(HEIGHT + 1);

   typedef enum logic [2:0] {StWaitHigh, StWaitLow, StFrame, StLine, StEnd} state_e;

   state_e            state_q, state_d;
   logic              cap_en_q, cap_en_d;
   logic [ColW-1:0]   col_q, col_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic              pair_seen_q, pair_seen_d;
   logic [15:0]       pixel_q, pixel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              clip_q, clip_d;
   logic              odd_q, odd_d;
   logic [7:0]        count_q, count_d;

   logic take_byte, end_line, go_end, in_bounds;

   assign in_bounds = (col_q < ColW'(WIDTH)) && (row_q < RowW'(HEIGHT));

   always_comb begin
      state_d     = state_q;
      cap_en_d    = cap_en_q;
      col_d       = col_q;
      row_d       = row_q;
      row_base_d  = row_base_q;
      phase_d     = phase_q;
      hi_d        = hi_q;
      pair_seen_d = pair_seen_q;
      pixel_d     = pixel_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      done_d      = 1'b0;
      clip_d      = clip_q;
      odd_d       = odd_q;
      count_d     = count_q;
      take_byte   = 1'b0;
      end_line    = 1'b0;
      go_end      = 1'b0;

      case (state_q)
         StWaitHigh: if (cam.vsync_in) state_d = StWaitLow;
         StWaitLow: begin
            if (!cam.vsync_in) begin
               cap_en_d    = cam.capture_en_in;
               col_d       = '0;
               row_d       = '0;
               row_base_d  = '0;
               phase_d     = 1'b0;
               pair_seen_d = 1'b0;
               clip_d      = 1'b0;
               odd_d       = 1'b0;
               state_d     = StFrame;
            end
         end
         StFrame: begin
            // vsync has priority over a simultaneous href byte
            if (cam.vsync_in) begin
               go_end  = 1'b1;
               state_d = StEnd;
            end else if (cam.href_in) begin
               take_byte = 1'b1;
               state_d   = StLine;
            end
         end
         StLine: begin
            if (cam.vsync_in) begin
               end_line = 1'b1;
               go_end   = 1'b1;
               state_d  = StEnd;
            end else if (cam.href_in) begin
               take_byte = 1'b1;
            end else begin
               end_line = 1'b1;
               state_d  = StFrame;
            end
         end
         StEnd:   state_d = StWaitLow;
         default: state_d = StWaitHigh;
      endcase

      if (go_end) begin
         done_d  = cap_en_q;
         count_d = count_q + {7'd0, cap_en_q};
      end

      if (take_byte) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            hi_d = cam.data_in;
         end else begin
            pair_seen_d = 1'b1;
            if (col_q < ColW'(WIDTH)) col_d = col_q + ColW'(1);
            if (in_bounds) begin
               if (cap_en_q) begin
                  we_d    = 1'b1;
                  pixel_d = {hi_q, cam.data_in};
                  addr_d  = row_base_q + ADDR_W'(col_q);
               end
            end else begin
               clip_d = 1'b1;
            end
         end
      end

      if (end_line) begin
         if (phase_q) odd_d = 1'b1;
         // Empty lines (no completed pair) do not consume a buffer row
         if (pair_seen_q) begin
            if (row_q < RowW'(HEIGHT)) row_d = row_q + RowW'(1);
            if (row_q < RowW'(HEIGHT - 1)) row_base_d = row_base_q + ADDR_W'(WIDTH);
         end
         col_d       = '0;
         phase_d     = 1'b0;
         pair_seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= StWaitHigh;
         cap_en_q    <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         row_base_q  <= '0;
         phase_q     <= 1'b0;
         hi_q        <= '0;
         pair_seen_q <= 1'b0;
         pixel_q     <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         clip_q      <= 1'b0;
         odd_q       <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cap_en_q    <= cap_en_d;
         col_q       <= col_d;
         row_q       <= row_d;
         row_base_q  <= row_base_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         pair_seen_q <= pair_seen_d;
         pixel_q     <= pixel_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         done_q      <= done_d;
         clip_q      <= clip_d;
         odd_q       <= odd_d;
         count_q     <= count_d;
      end
   end

   assign cam.pixel_out       = pixel_q;
   assign cam.addr_out        = addr_q;
   assign cam.we_out          = we_q;
   assign cam.frame_done_out  = done_q;
   assign cam.clip_out        = clip_q;
   assign cam.odd_byte_out    = odd_q;
   assign cam.frame_count_out = count_q;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture on a reduced frame: random camera bytes are checked against a
// frame-level model that predicts every buffer write and the per-frame status flags.
module tb_cam_pixel_capture;
   localparam int unsigned W  = 8;
   localparam int unsigned H  = 6;
   localparam int unsigned AW = 6;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   pix;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cam_pixel_capture_if #(.ADDR_W(AW)) cam ();

   cam_pixel_capture #(
      .WIDTH (W),
      .HEIGHT(H),
      .ADDR_W(AW)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .cam     (cam)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   int         n_fail = 0;
   wr_t        exp_q[$];
   int         m_row;
   bit         m_clip, m_odd, m_en, model_on, toggle_en;
   int         exp_done = 0;
   int         done_cnt = 0;
   logic [7:0] exp_count = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model of one completed pair: buffer row = count of non-empty lines so far
   task automatic model_pair(input int p, input logic [15:0] pix);
      if (!model_on) return;
      if (p < int'(W) && m_row < int'(H)) begin
         if (m_en) exp_q.push_back('{addr: AW'(m_row * int'(W) + p), pix: pix});
      end else begin
         m_clip = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && cam.frame_done_out) done_cnt++;
      if (rst_n && cam.we_out) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL unexpected_write: got addr %0h pixel %0h expected no write",
                   cam.addr_out, cam.pixel_out);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(cam.addr_out), 32'(e.addr));
            check("wr_pixel", 32'(cam.pixel_out), 32'(e.pix));
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_pixel"}, 32'(cam.pixel_out), 32'd0);
      check({tag, "_addr"}, 32'(cam.addr_out), 32'd0);
      check({tag, "_we"}, 32'(cam.we_out), 32'd0);
      check({tag, "_done"}, 32'(cam.frame_done_out), 32'd0);
      check({tag, "_clip"}, 32'(cam.clip_out), 32'd0);
      check({tag, "_odd"}, 32'(cam.odd_byte_out), 32'd0);
      check({tag, "_count"}, 32'(cam.frame_count_out), 32'd0);
   endtask

   // Drives one href line of n bytes; rst_at/abort_at (>=0) reset or raise vsync at that byte
   task automatic send_line(input int n, input bit chk_lat, input int rst_at, input int abort_at);
      logic [7:0] hi, b;
      int pairs, nb;
      pairs = 0;
      nb = n;
      hi = 8'd0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (chk_lat && i == 2) begin
            check("lat_we", 32'(cam.we_out), 32'd1);
            check("lat_addr", 32'(cam.addr_out), 32'd0);
            check("lat_pixel", 32'(cam.pixel_out), 32'h0000F81F);
         end
         if (i == rst_at) begin
            #2;
            rst_n = 1'b0;
            cam.href_in = 1'b0;
            #1;
            check_zero("rst_mid");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (i == abort_at) begin
            cam.vsync_in = 1'b1;
            cam.data_in = 8'($urandom);
            nb = i;
            break;
         end
         if (i < n) begin
            b = chk_lat && i == 0 ? 8'hF8 : chk_lat && i == 1 ? 8'h1F : 8'($urandom);
            if (toggle_en) cam.capture_en_in = 1'($urandom);
            cam.href_in = 1'b1;
            cam.data_in = b;
            if (i % 2 == 0) hi = b;
            else begin
               model_pair(pairs, {hi, b});
               pairs++;
            end
         end else begin
            cam.href_in = 1'b0;
         end
      end
      if (model_on) begin
         if (nb % 2 == 1) m_odd = 1'b1;
         if (pairs > 0 && m_row < int'(H)) m_row++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic begin_frame(input bit en, input bit tog);
      @(negedge clk);
      cam.vsync_in = 1'b1;
      cam.href_in = 1'b0;
      cam.capture_en_in = en;
      repeat (2) @(negedge clk);
      cam.vsync_in = 1'b0;
      m_row = 0;
      m_clip = 1'b0;
      m_odd = 1'b0;
      m_en = en;
      model_on = 1'b1;
      repeat (2) @(negedge clk);
      check("start_clip", 32'(cam.clip_out), 32'd0);
      check("start_odd", 32'(cam.odd_byte_out), 32'd0);
      toggle_en = tog;
   endtask

   task automatic end_frame(input string tag);
      @(negedge clk);
      toggle_en = 1'b0;
      cam.vsync_in = 1'b1;
      cam.href_in = 1'b0;
      repeat (3) @(negedge clk);
      if (m_en) begin
         exp_done++;
         exp_count++;
      end
      check({tag, "_clip"}, 32'(cam.clip_out), 32'(m_clip));
      check({tag, "_odd"}, 32'(cam.odd_byte_out), 32'(m_odd));
      check({tag, "_count"}, 32'(cam.frame_count_out), 32'(exp_count));
      check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int nl;
      cam.capture_en_in = 1'b0;
      cam.vsync_in = 1'b0;
      cam.href_in = 1'b0;
      cam.data_in = 8'd0;
      model_on = 1'b0;
      toggle_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Full frame, first pair F8/1F checks write latency
      begin_frame(1'b1, 1'b0);
      send_line(2 * W, 1'b1, -1, -1);
      for (int r = 1; r < int'(H); r++) send_line(2 * W, 1'b0, -1, -1);
      end_frame("normal");

      // Oversize lines and extra rows
      begin_frame(1'b1, 1'b0);
      repeat (2) send_line(2 * W + 6, 1'b0, -1, -1);
      repeat (H) send_line(2 * W, 1'b0, -1, -1);
      end_frame("oversize");

      // Odd-length lines, then a short line
      begin_frame(1'b1, 1'b0);
      send_line(2 * W + 1, 1'b0, -1, -1);
      send_line(2 * W, 1'b0, -1, -1);
      send_line(5, 1'b0, -1, -1);
      end_frame("odd");

      // Disabled at frame start; capture_en toggles mid-frame
      begin_frame(1'b0, 1'b1);
      repeat (3) send_line(2 * W, 1'b0, -1, -1);
      end_frame("disabled");

      begin_frame(1'b1, 1'b0);
      repeat (3) send_line(2 * W, 1'b0, -1, -1);
      end_frame("reenabled");

      // Random frames, some cut short by vsync during a line
      for (int f = 0; f < 8; f++) begin
         begin_frame(f % 4 != 3, 1'($urandom));
         nl = $urandom_range(1, H + 2);
         for (int l = 0; l < nl; l++) begin
            if (l == nl - 1 && $urandom_range(0, 1) == 1)
               send_line(2 * W + 3, 1'b0, -1, $urandom_range(0, 2 * W + 2));
            else
               send_line($urandom_range(0, 2 * W + 3), 1'b0, -1, -1);
         end
         end_frame("random");
      end

      // Reset in the middle of a line; bytes before the next vsync pulse must not write
      begin_frame(1'b1, 1'b0);
      repeat (2) send_line(2 * W, 1'b0, -1, -1);
      send_line(2 * W, 1'b0, 6, -1);
      model_on = 1'b0;
      exp_count = 8'd0;
      repeat (2) send_line(2 * W, 1'b0, -1, -1);
      begin_frame(1'b1, 1'b0);
      repeat (2) send_line(2 * W, 1'b0, -1, -1);
      end_frame("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Upstream stage of the drawing pipeline.
- Receives the camera's 8-bit parallel byte stream (vsync/href/data, two bytes per RGB565 pixel) and assembles 16-bit pixels.
- Writes each pixel into the user frame buffer at a linear address row*WIDTH+col. The drawing logic later reads pixel_in from that buffer; its recolour stage thresholds green at bits [10:5].
- Tracks frame and line boundaries, clips oversize frames and reports frame completion and framing errors.

Parameters:
- WIDTH, 320, pixels per line written to the buffer.
- HEIGHT, 240, lines per frame written to the buffer.
- ADDR_W, 17, buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk_in  in  1  camera pixel clock; all logic on posedge.
- rst_n_in  in  1  asynchronous, active-low reset.
- capture_en_in  in  1  capture request; sampled only at frame start.
- vsync_in  in  1  camera vsync; high = vertical blanking.
- href_in  in  1  camera href; high = valid byte on data_in.
- data_in  in  8  camera byte.
- pixel_out  out  16  assembled RGB565 pixel {R[15:11], G[10:5], B[4:0]}.
- addr_out  out  ADDR_W  frame-buffer write address.
- we_out  out  1  write strobe, one cycle per accepted pixel.
- frame_done_out  out  1  one-cycle pulse at the end of a captured frame.
- clip_out  out  1  sticky per frame: a pixel or line exceeded WIDTH/HEIGHT.
- odd_byte_out  out  1  sticky per frame: a line ended on an unpaired byte.
- frame_count_out  out  8  completed captured frames, wraps at 255.

Behaviour:
- Reset (async assert, sync release):
  - state = WAIT_SYNC.
  - All outputs, col, row, row_base, byte phase and high-byte register are 0.
  - Reset mid-line abandons the line; capture restarts only after the next full vsync pulse.
- WAIT_SYNC: wait for vsync_in high, then low (falling edge = frame start).
  - At that edge, sample capture_en_in into cap_en.
  - Clear col, row, row_base, clip_out, odd_byte_out.
  - Go to FRAME.
- FRAME (href low, between lines):
  - href_in high → LINE; that same cycle is processed as the first byte.
  - vsync_in rising → END.
- LINE:
  - Each cycle with href_in high samples data_in and toggles the phase; phase 0 loads hi = data_in.
  - Phase 1 forms {hi, data_in}. On the next cycle: pixel_out = that value, addr_out = row_base + col, we_out = cap_en & (col < WIDTH) & (row < HEIGHT).
  - Write latency: 1 cycle after the second byte.
  - col increments on every completed pair, saturating at WIDTH.
  - A pair with col >= WIDTH or row >= HEIGHT is not written and sets clip_out.
  - href_in falling:
    - If phase = 1, drop the lone byte and set odd_byte_out.
    - If at least one pair was completed this line: row += 1 (saturating at HEIGHT) and row_base += WIDTH (only while row < HEIGHT).
    - col = 0, phase = 0, go to FRAME.
  - vsync_in rising during LINE: abort the line the same way, then → END.
- END (one cycle):
  - frame_done_out = cap_en; frame_count_out += cap_en.
  - Go to WAIT_SYNC, which now waits for the falling edge only, since vsync is already high.
- Outputs:
  - we_out and frame_done_out are single-cycle pulses.
  - pixel_out and addr_out hold their last values when we_out = 0.
  - clip_out and odd_byte_out stay valid through END and clear at the next frame start.
- Short lines (fewer than WIDTH pairs): the remaining addresses of that row are left unwritten, and the next line starts at the next row_base.
- Frames with fewer than HEIGHT lines: frame_done_out still pulses.
- Arithmetic:
  - The address is a registered sum; no multiplier is used.
  - row_base is at most (HEIGHT-1)*WIDTH, so addr_out never exceeds WIDTH*HEIGHT-1.
- Simultaneous events:
  - vsync rise with href high: vsync wins; the byte is ignored.
  - capture_en_in changing mid-frame has no effect.

Test Plan:
- Normal frame: reset, vsync pulse, 240 lines × 640 bytes, pixel n of line r = {r[7:0], n[7:0]}, capture_en=1 → 76800 we_out pulses. Addr 0..76799 in order; pixel at addr 321 = 16'h0101; single frame_done_out at vsync rise; frame_count_out=1; clip_out=0; odd_byte_out=0.
- Latency/byte order: bytes 8'hF8, 8'h1F on line 0 → one cycle after the 8'h1F sample, we_out=1, addr_out=0, pixel_out=16'hF81F.
- Oversize: 2 lines of 700 bytes (350 pairs), then 250 more lines → writes only at col<320 and rows<240; clip_out=1 at END; max addr 76799.
- Odd line: 641 bytes on line 0 → 320 writes; odd_byte_out=1; line 1 starts at addr 320.
- Disabled: capture_en=0 at frame start, raised mid-frame → no we_out and no frame_done_out; the next frame, started with en=1, captures normally.
- Reset mid-line at pixel 100 of line 5 → outputs 0 immediately; bytes before the next vsync fall produce no writes; the next frame starts at addr 0.
